// File: rtl/fpu_result_buffer.sv
// ---------------------------------------------------------------------------
// fpu_result_buffer
//   Registered result stage behind the FPU add/sub units. Single-precision
//   results and their error/overflow flags are queued in a small FIFO and
//   handed to the consumer in order over a valid/ready handshake. Sticky
//   exception flags accumulate until cleared, and the head word is classified
//   (zero / finite / infinity / NaN).
//
//   Optional feature macro: FPU_RESULT_BUFFER_OVF_STATS_EN
//     defined   -> ovf_count is a saturating 16-bit count of accepted
//                  overflow entries, cleared by clear_sticky.
//     undefined -> ovf_count is tied to 0 and no counter register exists.
//
//   Parameters
//     DEPTH  FIFO entries (power of two, >= 2)
//     PTR_W  log2(DEPTH)
//
//   Ports
//     clk, rst_n              clock, async active-low reset
//     in_valid/in_ready       producer handshake
//     in_result/in_error/in_overflow   entry written on push
//     out_valid/out_ready     consumer handshake
//     out_result/out_error/out_overflow/out_class   head entry (0 when empty)
//     count                   occupied entries, 0..DEPTH
//     sticky_error/sticky_overflow     accumulated exception flags
//     clear_sticky            synchronous clear of sticky flags / ovf_count
//     ovf_count               overflow statistics counter
// ---------------------------------------------------------------------------
module fpu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_error,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_error,
    output logic             out_overflow,
    output logic [1:0]       out_class,
    output logic [PTR_W:0]   count,
    output logic             sticky_error,
    output logic             sticky_overflow,
    input  logic             clear_sticky,
    output logic [15:0]      ovf_count
);

    typedef struct packed {
        logic [31:0] res;
        logic        err;
        logic        ovf;
    } entry_t;

    localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;
    logic               r_sticky_err;
    logic               r_sticky_ovf;

    logic               w_push;
    logic               w_pop;
    entry_t             w_head;
    logic [7:0]         w_exp;
    logic [22:0]        w_frac;

    // in_ready looks only at the registered count, so a full buffer never
    // accepts a new entry even when the consumer pops in the same cycle.
    assign in_ready  = (r_count != C_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = r_count;

    // Pointers are exactly PTR_W bits wide, so wrap modulo DEPTH is natural.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (PTR_W+1)'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - (PTR_W+1)'(1);
        end
    end

    // Storage carries no reset; validity is tracked entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= '{res: in_result, err: in_error, ovf: in_overflow};
    end

    assign w_head = r_mem[r_rptr];

    always_comb begin
        out_result   = '0;
        out_error    = 1'b0;
        out_overflow = 1'b0;
        if (out_valid) begin
            out_result   = w_head.res;
            out_error    = w_head.err;
            out_overflow = w_head.ovf;
        end
    end

    assign w_exp  = out_result[30:23];
    assign w_frac = out_result[22:0];

    // out_result is already zero when empty, which decodes to class 00.
    always_comb begin
        out_class = 2'b01;
        if (w_exp == 8'h00)
            out_class = 2'b00;
        else if (w_exp == 8'hFF)
            out_class = (w_frac == '0) ? 2'b10 : 2'b11;
    end

    // A setting push takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_err <= 1'b0;
            r_sticky_ovf <= 1'b0;
        end else begin
            if (w_push && in_error)    r_sticky_err <= 1'b1;
            else if (clear_sticky)     r_sticky_err <= 1'b0;
            if (w_push && in_overflow) r_sticky_ovf <= 1'b1;
            else if (clear_sticky)     r_sticky_ovf <= 1'b0;
        end
    end

    assign sticky_error    = r_sticky_err;
    assign sticky_overflow = r_sticky_ovf;

`ifdef FPU_RESULT_BUFFER_OVF_STATS_EN
    logic [15:0] r_ovf_count;
    logic        w_ovf_inc;

    assign w_ovf_inc = w_push & in_overflow;

    // Clear restarts the count; a same-cycle increment makes it 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf_count <= '0;
        else if (clear_sticky)
            r_ovf_count <= {15'd0, w_ovf_inc};
        else if (w_ovf_inc && r_ovf_count != 16'hFFFF)
            r_ovf_count <= r_ovf_count + 16'd1;
    end

    assign ovf_count = r_ovf_count;
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_fpu_result_buffer.sv
module tb_fpu_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_error;
    logic        in_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_error;
    logic        out_overflow;
    logic [1:0]  out_class;
    logic [2:0]  count;
    logic        sticky_error;
    logic        sticky_overflow;
    logic        clear_sticky;
    logic [15:0] ovf_count;

    fpu_result_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_error(in_error), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_error(out_error), .out_overflow(out_overflow), .out_class(out_class),
        .count(count), .sticky_error(sticky_error), .sticky_overflow(sticky_overflow),
        .clear_sticky(clear_sticky), .ovf_count(ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] ir;
        logic        ie;
        logic        io;
        logic        ordy;
        logic        clr;
        logic        eov;
        logic [31:0] er;
        logic        ee;
        logic        eo;
        logic [1:0]  ec;
        logic [2:0]  en;
        logic        erdy;
        logic        ese;
        logic        eso;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    int n_pass = 0;
    int n_tot  = 0;
    int m_cnt  = 0;
    int m_ovf  = 0;
    logic [31:0] q [$];

    function automatic vec_t mk(input logic iv, input logic [31:0] ir, input logic ie, input logic io,
                                input logic ordy, input logic clr, input logic eov, input logic [31:0] er,
                                input logic ee, input logic eo, input logic [1:0] ec, input logic [2:0] en,
                                input logic erdy, input logic ese, input logic eso);
        vec_t v;
        v.iv = iv; v.ir = ir; v.ie = ie; v.io = io; v.ordy = ordy; v.clr = clr;
        v.eov = eov; v.er = er; v.ee = ee; v.eo = eo; v.ec = ec; v.en = en;
        v.erdy = erdy; v.ese = ese; v.eso = eso;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    endtask

    // Drive one cycle of inputs, track occupancy and the overflow counter in
    // the bench model, then sample 1 time unit after the rising edge.
    task automatic drive(input logic iv, input logic [31:0] ir, input logic ie, input logic io,
                         input logic ordy, input logic clr);
        bit push, pop;
        in_valid = iv; in_result = ir; in_error = ie; in_overflow = io;
        out_ready = ordy; clear_sticky = clr;
        push = iv && (m_cnt != 4);
        pop  = ordy && (m_cnt != 0);
        if (clr) m_ovf = (push && io) ? 1 : 0;
        else if (push && io && m_ovf != 65535) m_ovf++;
        m_cnt = m_cnt + int'(push) - int'(pop);
        @(posedge clk);
        #1;
    endtask

    task automatic check_ovf(input int idx);
`ifdef FPU_RESULT_BUFFER_OVF_STATS_EN
        chk("ovf_count", idx, 32'(ovf_count), 32'(m_ovf));
`else
        chk("ovf_count_off", idx, 32'(ovf_count), 32'd0);
`endif
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        chk("out_valid", idx, 32'(out_valid), 32'(v.eov));
        chk("out_result", idx, out_result, v.er);
        chk("out_error", idx, 32'(out_error), 32'(v.ee));
        chk("out_overflow", idx, 32'(out_overflow), 32'(v.eo));
        chk("out_class", idx, 32'(out_class), 32'(v.ec));
        chk("count", idx, 32'(count), 32'(v.en));
        chk("in_ready", idx, 32'(in_ready), 32'(v.erdy));
        chk("sticky_error", idx, 32'(sticky_error), 32'(v.ese));
        chk("sticky_overflow", idx, 32'(sticky_overflow), 32'(v.eso));
        check_ovf(idx);
    endtask

    initial begin
        //            iv ir            ie io rdy clr | ov res          e  o  cls   cnt rdy se so
        vt[0]  = mk(1, 32'h3F800000, 0, 0, 0, 0,   1, 32'h3F800000, 0, 0, 2'b01, 1, 1, 0, 0);
        vt[1]  = mk(0, 32'h0,        0, 0, 1, 0,   0, 32'h0,        0, 0, 2'b00, 0, 1, 0, 0);
        vt[2]  = mk(1, 32'h40000000, 0, 0, 0, 0,   1, 32'h40000000, 0, 0, 2'b01, 1, 1, 0, 0);
        vt[3]  = mk(1, 32'h40400000, 0, 0, 0, 0,   1, 32'h40000000, 0, 0, 2'b01, 2, 1, 0, 0);
        vt[4]  = mk(1, 32'h40800000, 0, 0, 0, 0,   1, 32'h40000000, 0, 0, 2'b01, 3, 1, 0, 0);
        vt[5]  = mk(1, 32'h40A00000, 0, 0, 0, 0,   1, 32'h40000000, 0, 0, 2'b01, 4, 0, 0, 0);
        vt[6]  = mk(1, 32'h40C00000, 0, 0, 0, 0,   1, 32'h40000000, 0, 0, 2'b01, 4, 0, 0, 0);
        vt[7]  = mk(1, 32'h40C00000, 0, 0, 1, 0,   1, 32'h40400000, 0, 0, 2'b01, 3, 1, 0, 0);
        vt[8]  = mk(1, 32'h40C00000, 0, 0, 1, 0,   1, 32'h40800000, 0, 0, 2'b01, 3, 1, 0, 0);
        vt[9]  = mk(0, 32'h0,        0, 0, 1, 0,   1, 32'h40A00000, 0, 0, 2'b01, 2, 1, 0, 0);
        vt[10] = mk(0, 32'h0,        0, 0, 1, 0,   1, 32'h40C00000, 0, 0, 2'b01, 1, 1, 0, 0);
        vt[11] = mk(0, 32'h0,        0, 0, 1, 0,   0, 32'h0,        0, 0, 2'b00, 0, 1, 0, 0);
        vt[12] = mk(1, 32'h7F800000, 0, 1, 0, 0,   1, 32'h7F800000, 0, 1, 2'b10, 1, 1, 0, 1);
        vt[13] = mk(1, 32'h7FC00000, 1, 0, 0, 0,   1, 32'h7F800000, 0, 1, 2'b10, 2, 1, 1, 1);
        vt[14] = mk(1, 32'h80000000, 0, 0, 1, 0,   1, 32'h7FC00000, 1, 0, 2'b11, 2, 1, 1, 1);
        vt[15] = mk(0, 32'h0,        0, 0, 1, 0,   1, 32'h80000000, 0, 0, 2'b00, 1, 1, 1, 1);
        vt[16] = mk(0, 32'h0,        0, 0, 1, 0,   0, 32'h0,        0, 0, 2'b00, 0, 1, 1, 1);
        vt[17] = mk(1, 32'h3F800000, 0, 1, 0, 1,   1, 32'h3F800000, 0, 1, 2'b01, 1, 1, 0, 1);
        vt[18] = mk(0, 32'h0,        0, 0, 1, 1,   0, 32'h0,        0, 0, 2'b00, 0, 1, 0, 0);
        vt[19] = mk(1, 32'h00000001, 0, 0, 0, 0,   1, 32'h00000001, 0, 0, 2'b00, 1, 1, 0, 0);
        vt[20] = mk(1, 32'hFF800000, 0, 0, 1, 0,   1, 32'hFF800000, 0, 0, 2'b10, 1, 1, 0, 0);
        vt[21] = mk(1, 32'h7F7FFFFF, 0, 0, 1, 0,   1, 32'h7F7FFFFF, 0, 0, 2'b01, 1, 1, 0, 0);
        vt[22] = mk(0, 32'h0,        0, 0, 1, 0,   0, 32'h0,        0, 0, 2'b00, 0, 1, 0, 0);

        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_error = 1'b0;
        in_overflow = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_out_result", 0, out_result, 32'd0);
        chk("rst_out_class", 0, 32'(out_class), 32'd0);
        chk("rst_count", 0, 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 0, 32'(in_ready), 32'd1);
        chk("rst_sticky", 0, 32'({sticky_error, sticky_overflow}), 32'd0);
        check_ovf(0);

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].iv, vt[i].ir, vt[i].ie, vt[i].io, vt[i].ordy, vt[i].clr);
            check_vec(i, vt[i]);
        end

        // Pointer wrap: keep three entries resident and stream 12 push+pop
        // cycles through (three laps of a 4-deep ring), checking order.
        for (int k = 0; k < 3; k++) begin
            q.push_back(32'h3F800000 + 32'(k));
            drive(1'b1, 32'h3F800000 + 32'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("wrap_fill_count", 0, 32'(count), 32'd3);
        for (int k = 3; k < 15; k++) begin
            q.push_back(32'h3F800000 + 32'(k));
            void'(q.pop_front());
            drive(1'b1, 32'h3F800000 + 32'(k), 1'b0, 1'b0, 1'b1, 1'b0);
            chk("wrap_head", k, out_result, q[0]);
            chk("wrap_count", k, 32'(count), 32'd3);
        end
        for (int k = 0; k < 3; k++) begin
            void'(q.pop_front());
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (k < 2) chk("drain_head", k, out_result, q[0]);
        end
        chk("drain_valid", 0, 32'(out_valid), 32'd0);

        // Asynchronous reset while holding three entries and sticky flags.
        drive(1'b1, 32'h7FC00000, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("pre_rst_count", 0, 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 0, 32'(out_valid), 32'd0);
        chk("async_rst_count", 0, 32'(count), 32'd0);
        chk("async_rst_result", 0, out_result, 32'd0);
        chk("async_rst_sticky", 0, 32'({sticky_error, sticky_overflow}), 32'd0);
        chk("async_rst_ovf", 0, 32'(ovf_count), 32'd0);
        m_cnt = 0; m_ovf = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_valid", 0, 32'(out_valid), 32'd0);
        chk("post_rst_ready", 0, 32'(in_ready), 32'd1);

`ifdef FPU_RESULT_BUFFER_OVF_STATS_EN
        // Saturation: one overflow push, then push+pop each cycle.
        drive(1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovf_three", 0, 32'(ovf_count), 32'd3);
        for (int k = 3; k < 65535; k++)
            drive(1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovf_reach_max", 0, 32'(ovf_count), 32'h0000FFFF);
        drive(1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovf_saturated", 0, 32'(ovf_count), 32'h0000FFFF);
        drive(1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("ovf_clear_inc", 0, 32'(ovf_count), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovf_clear", 0, 32'(ovf_count), 32'd0);
`else
        for (int k = 0; k < 4; k++)
            drive(1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovf_off_after_pushes", 0, 32'(ovf_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
